// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared divider constants and state encoding
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  // Controller-side names for the start request and divide-by-zero flag levels
  localparam logic DIV_CTRL_START = 1'b1;
  localparam logic DIV_ZERO_FLAG  = 1'b1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_unit_step.sv
// rtl/div_unit_step.sv - one restoring division iteration on unsigned magnitudes
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_r,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0]   w_r_sh;
  logic [WIDTH-1:0] w_q_sh;
  logic [WIDTH:0]   w_d_ext;
  logic             w_ge;

  assign w_r_sh  = {i_r[WIDTH-1:0], i_q[WIDTH-1]};
  assign w_q_sh  = {i_q[WIDTH-2:0], 1'b0};
  assign w_d_ext = {1'b0, i_d};
  // A set top bit of the incoming remainder means the shifted value already exceeds any divisor
  assign w_ge    = i_r[WIDTH] | (w_r_sh >= w_d_ext);

  // Subtract the divisor when it fits and shift a 1 into the quotient
  always_comb begin
    o_r = w_r_sh;
    o_q = w_q_sh;
    if (w_ge) begin
      o_r    = w_r_sh - w_d_ext;
      o_q[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multicycle signed restoring divider producing Lo (quotient) and Hi (remainder)
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] Hi,
  output logic             busy,
  output logic             done,
  output logic             divZero
);

  div_state_t       r_state;
  div_state_t       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_busy;
  logic             r_done;
  logic             r_divzero;

  logic             w_req;
  logic             w_b_zero;
  logic             w_start;
  logic             w_zero_req;
  logic             w_last;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_step_r;
  logic [WIDTH-1:0] w_step_q;

  assign w_req      = (r_state == DIV_IDLE) && (DivCtrl == DIV_CTRL_START);
  assign w_b_zero   = (B == '0);
  assign w_start    = w_req && !w_b_zero;
  assign w_zero_req = w_req && w_b_zero;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  // Magnitudes are unsigned, so the most negative value maps onto its own bit pattern
  assign w_abs_a    = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign w_abs_b    = B[WIDTH-1] ? (~B + 1'b1) : B;

  div_unit_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_r (r_r),
    .i_q (r_q),
    .i_d (r_d),
    .o_r (w_step_r),
    .o_q (w_step_q)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: IDLE -> CALC for WIDTH steps -> FIX -> IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DIV_IDLE: if (w_start) w_next_state = DIV_CALC;
      DIV_CALC: if (w_last)  w_next_state = DIV_FIX;
      DIV_FIX:               w_next_state = DIV_IDLE;
      default:               w_next_state = DIV_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and iteration counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_r      <= '0;
      r_q      <= '0;
      r_d      <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (w_start) begin
            r_q      <= w_abs_a;
            r_d      <= w_abs_b;
            r_r      <= '0;
            r_cnt    <= '0;
            r_sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
            r_sign_r <= A[WIDTH-1];
          end
        end
        DIV_CALC: begin
          r_r   <= w_step_r;
          r_q   <= w_step_q;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers and status pulses; busy also covers the cycle in which done is shown
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lo      <= '0;
      r_hi      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_divzero <= w_zero_req ? DIV_ZERO_FLAG : 1'b0;
      r_busy    <= (w_next_state != DIV_IDLE) || (r_state == DIV_FIX);
      if (r_state == DIV_FIX) begin
        r_lo   <= r_sign_q ? (~r_q + 1'b1) : r_q;
        r_hi   <= r_sign_r ? (~r_r[WIDTH-1:0] + 1'b1) : r_r[WIDTH-1:0];
        r_done <= 1'b1;
      end
    end
  end

  assign Lo      = r_lo;
  assign Hi      = r_hi;
  assign busy    = r_busy;
  assign done    = r_done;
  assign divZero = r_divzero;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        DivCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Lo;
  logic [31:0] Hi;
  logic        busy;
  logic        done;
  logic        divZero;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t vecs[9];

  div_unit dut (
    .clk     (clk),
    .reset   (reset),
    .DivCtrl (DivCtrl),
    .A       (A),
    .B       (B),
    .Lo      (Lo),
    .Hi      (Hi),
    .busy    (busy),
    .done    (done),
    .divZero (divZero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Reference: MIPS signed division via wide integer arithmetic (truncating quotient, dividend-signed remainder)
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = 32'(sa / sb);
    r  = 32'(sa % sb);
  endfunction

  // Start a division, optionally re-pulse DivCtrl mid-flight, and wait (bounded) for done
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int repulse_at,
                         output logic [31:0] lo, output logic [31:0] hi,
                         output int lat, output int busy_bad);
    @(negedge clk);
    A = a;
    B = b;
    DivCtrl = 1'b1;
    @(posedge clk);
    #1;
    DivCtrl = 1'b0;
    A = $urandom;
    B = $urandom;
    lat = 0;
    busy_bad = 0;
    while (!done && lat < 40) begin
      if (!busy) busy_bad++;
      DivCtrl = (lat == repulse_at) ? 1'b1 : 1'b0;
      if (lat == repulse_at) begin
        A = 32'd50;
        B = 32'd3;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    DivCtrl = 1'b0;
    if (!busy) busy_bad++;
    lo = Lo;
    hi = Hi;
  endtask

  task automatic check_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int repulse_at);
    logic [31:0] lo;
    logic [31:0] hi;
    int lat;
    int busy_bad;
    run_div(a, b, repulse_at, lo, hi, lat, busy_bad);
    check({name, "_lo"}, lo, exp_lo);
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_latency"}, 32'(lat), 32'd33);
    check({name, "_busy_gaps"}, 32'(busy_bad), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] eq;
    logic [31:0] er;
    int extra;

    vecs[0] = '{32'd100,      32'd7,        32'd14,       32'd2};
    vecs[1] = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE};
    vecs[2] = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2};
    vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    vecs[4] = '{32'd5,        32'd9,        32'd0,        32'd5};
    vecs[5] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE};
    vecs[6] = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF};
    vecs[7] = '{32'h80000000, 32'd1,        32'h80000000, 32'd0};
    vecs[8] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF};

    reset = 1'b0;
    DivCtrl = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_lo", Lo, 32'd0);
    check("reset_hi", Hi, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_divzero", 32'(divZero), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table vectors, issued back to back at the earliest accepted edge
    for (int i = 0; i < 9; i++) begin
      check_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, -1);
    end

    // done is a single-cycle pulse and busy drops with it
    check_div("preload", 32'd100, 32'd7, 32'd14, 32'd2, -1);
    @(posedge clk);
    #1;
    check("done_pulse_end", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);

    // Divide by zero: flag for one cycle, no busy/done, results untouched
    @(negedge clk);
    A = 32'd123;
    B = 32'd0;
    DivCtrl = 1'b1;
    @(posedge clk);
    #1;
    DivCtrl = 1'b0;
    check("dz_flag", 32'(divZero), 32'd1);
    check("dz_busy", 32'(busy), 32'd0);
    check("dz_done", 32'(done), 32'd0);
    extra = 0;
    @(posedge clk);
    #1;
    check("dz_flag_end", 32'(divZero), 32'd0);
    for (int k = 0; k < 40; k++) begin
      if (busy || done || divZero) extra++;
      @(posedge clk);
      #1;
    end
    check("dz_no_activity", 32'(extra), 32'd0);
    check("dz_lo_kept", Lo, 32'd14);
    check("dz_hi_kept", Hi, 32'd2);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    A = 32'd100;
    B = 32'd7;
    DivCtrl = 1'b1;
    @(posedge clk);
    #1;
    DivCtrl = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("mid_reset_lo", Lo, 32'd0);
    check("mid_reset_hi", Hi, 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    check_div("after_reset", 32'd100, 32'd7, 32'd14, 32'd2, -1);

    // Re-pulsed DivCtrl during CALC is ignored
    check_div("repulse", 32'd100, 32'd7, 32'd14, 32'd2, 5);

    // Randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) begin
        rb = 32'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
      end
      if (i % 5 == 1) ra = 32'($urandom_range(0, 30));
      if (rb == 32'd0) rb = 32'd1;
      ref_div(ra, rb, eq, er);
      check_div($sformatf("rand%0d", i), ra, rb, eq, er, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
